// File: rtl/umi_reg_arbiter.sv
// Round-robin arbiter sharing one register/SRAM port between N requesters; read data returns RDLAT+1 cycles after acceptance.
// Define UMI_REG_ARB_LOCK_EN to let a requester hold the grant across transactions via req_lock.
module umi_reg_arbiter #(
   parameter int N     = 2,
   parameter int AW    = 64,
   parameter int RW    = 32,
   parameter int RDLAT = 1
) (
   input  logic            clk,
   input  logic            nreset,
   input  logic [N-1:0]    req_valid,
   input  logic [N-1:0]    req_write,
   input  logic [N-1:0]    req_lock,
   input  logic [N*AW-1:0] req_addr,
   input  logic [N*RW-1:0] req_wrdata,
   output logic [N-1:0]    req_ready,
   output logic [N-1:0]    rsp_valid,
   output logic [RW-1:0]   rsp_rddata,
   output logic [AW-1:0]   reg_addr,
   output logic            reg_write,
   output logic            reg_read,
   output logic [RW-1:0]   reg_wrdata,
   input  logic [RW-1:0]   reg_rddata
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] gidx;
   logic [IW-1:0] cand;
   logic          found;
   logic          accept;

   logic [AW-1:0] reg_addr_q;
   logic [RW-1:0] reg_wrdata_q;
   logic          reg_write_q;
   logic          reg_read_q;
   logic [IW-1:0] reg_id_q;

   logic [RDLAT-1:0] pipe_vld_q;
   logic [IW-1:0]    pipe_id_q [RDLAT];

`ifdef UMI_REG_ARB_LOCK_EN
   logic          lock_q, lock_d;
   logic [IW-1:0] lock_id_q, lock_id_d;
`else
   logic          unused_lock;
   assign unused_lock = ^req_lock;
`endif

   // Search starts one past the last winner so every requester gets a turn.
   always_comb begin
      found = 1'b0;
      gidx  = ptr_q;
      cand  = '0;
      for (int k = 1; k <= N; k++) begin
         cand = IW'((int'(ptr_q) + k) % N);
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            gidx  = cand;
         end
      end
`ifdef UMI_REG_ARB_LOCK_EN
      if (lock_q) begin
         found = req_valid[lock_id_q];
         gidx  = lock_id_q;
      end
`endif
   end

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < N; i++) begin
         req_ready[i] = found & nreset & (gidx == IW'(i));
      end
   end

   assign accept = |req_ready;
   assign ptr_d  = accept ? gidx : ptr_q;

`ifdef UMI_REG_ARB_LOCK_EN
   always_comb begin
      lock_d    = lock_q;
      lock_id_d = lock_id_q;
      if (accept) begin
         lock_d    = req_lock[gidx];
         lock_id_d = gidx;
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         lock_q    <= 1'b0;
         lock_id_q <= '0;
      end else begin
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
      end
   end
`endif

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         ptr_q        <= IW'(N - 1);
         reg_addr_q   <= '0;
         reg_wrdata_q <= '0;
         reg_write_q  <= 1'b0;
         reg_read_q   <= 1'b0;
         reg_id_q     <= '0;
      end else begin
         ptr_q       <= ptr_d;
         reg_write_q <= accept & req_write[gidx];
         reg_read_q  <= accept & ~req_write[gidx];
         if (accept) begin
            reg_addr_q   <= req_addr[gidx*AW +: AW];
            reg_wrdata_q <= req_wrdata[gidx*RW +: RW];
            reg_id_q     <= gidx;
         end
      end
   end

   // Requester ID follows the read strobe so it lines up with reg_rddata.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         pipe_vld_q <= '0;
         for (int i = 0; i < RDLAT; i++) pipe_id_q[i] <= '0;
      end else begin
         pipe_vld_q[0] <= reg_read_q;
         pipe_id_q[0]  <= reg_id_q;
         for (int i = 1; i < RDLAT; i++) begin
            pipe_vld_q[i] <= pipe_vld_q[i-1];
            pipe_id_q[i]  <= pipe_id_q[i-1];
         end
      end
   end

   always_comb begin
      rsp_valid = '0;
      for (int i = 0; i < N; i++) begin
         rsp_valid[i] = pipe_vld_q[RDLAT-1] & (pipe_id_q[RDLAT-1] == IW'(i));
      end
   end

   assign rsp_rddata = reg_rddata;
   assign reg_addr   = reg_addr_q;
   assign reg_wrdata = reg_wrdata_q;
   assign reg_write  = reg_write_q;
   assign reg_read   = reg_read_q;

endmodule

// File: tb/tb_umi_reg_arbiter.sv
// Directed bench: RDLAT=1 and RDLAT=3 instances share the same requester stimulus.
module tb_umi_reg_arbiter;

   logic         clk = 1'b0;
   logic         nreset;
   logic [1:0]   req_valid, req_write, req_lock;
   logic [127:0] req_addr;
   logic [63:0]  req_wrdata;

   logic [1:0]   req_ready, rsp_valid, req_ready3, rsp_valid3;
   logic [31:0]  rsp_rddata, rsp_rddata3, reg_wrdata, reg_wrdata3, reg_rddata, reg_rddata3;
   logic [63:0]  reg_addr, reg_addr3;
   logic         reg_write, reg_read, reg_write3, reg_read3;

   logic [31:0]  mem [256];
   logic [31:0]  p3 [3];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   umi_reg_arbiter #(.N(2), .AW(64), .RW(32), .RDLAT(1)) dut (
      .clk(clk), .nreset(nreset), .req_valid(req_valid), .req_write(req_write),
      .req_lock(req_lock), .req_addr(req_addr), .req_wrdata(req_wrdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rddata(rsp_rddata),
      .reg_addr(reg_addr), .reg_write(reg_write), .reg_read(reg_read),
      .reg_wrdata(reg_wrdata), .reg_rddata(reg_rddata));

   umi_reg_arbiter #(.N(2), .AW(64), .RW(32), .RDLAT(3)) dut3 (
      .clk(clk), .nreset(nreset), .req_valid(req_valid), .req_write(req_write),
      .req_lock(req_lock), .req_addr(req_addr), .req_wrdata(req_wrdata),
      .req_ready(req_ready3), .rsp_valid(rsp_valid3), .rsp_rddata(rsp_rddata3),
      .reg_addr(reg_addr3), .reg_write(reg_write3), .reg_read(reg_read3),
      .reg_wrdata(reg_wrdata3), .reg_rddata(reg_rddata3));

   // One-cycle SRAM behind the RDLAT=1 instance.
   always @(posedge clk) begin
      if (reg_write) mem[reg_addr[7:0]] <= reg_wrdata;
      if (reg_read) reg_rddata <= mem[reg_addr[7:0]];
   end

   // Three-cycle ROM behind the RDLAT=3 instance: data = 0x3000_0000 + addr.
   always @(posedge clk) begin
      p3[0] <= reg_read3 ? (reg_addr3[31:0] + 32'h3000_0000) : 32'h0;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign reg_rddata3 = p3[2];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      nreset = 1'b0;
      req_valid = 2'b00;
      tick;
      nreset = 1'b1;
   endtask

   task automatic test_reset;
      nreset = 1'b1;
      req_valid = 2'b00; req_write = 2'b00; req_lock = 2'b00;
      req_addr = '0; req_wrdata = '0;
      #2;
      nreset = 1'b0;
      req_valid = 2'b11;
      #1;
      checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got %b want 00", req_ready); end
      checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_rsp got %b want 00", rsp_valid); end
      checks++; if ({reg_read, reg_write} !== 2'b00) begin failures++; $display("FAIL reset_regop got %b want 00", {reg_read, reg_write}); end
      checks++; if (reg_addr !== 64'h0) begin failures++; $display("FAIL reset_addr got %h want 0", reg_addr); end
      tick; tick;
      checks++; if (req_ready !== 2'b00 || reg_read !== 1'b0 || rsp_valid3 !== 2'b00) begin
         failures++; $display("FAIL reset_held got ready=%b rd=%b rsp3=%b want 00/0/00", req_ready, reg_read, rsp_valid3); end
      req_valid = 2'b00;
      nreset = 1'b1;
      tick;
   endtask

   task automatic test_single_read;
      do_reset;
      req_valid = 2'b01; req_write = 2'b00; req_addr = {64'h0, 64'h8};
      #1;
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL single_ready got %b want 01", req_ready); end
      tick;
      req_valid = 2'b00;
      #1;
      checks++; if (reg_read !== 1'b1 || reg_write !== 1'b0 || reg_addr !== 64'h8) begin
         failures++; $display("FAIL single_regop got rd=%b wr=%b addr=%h want 1/0/8", reg_read, reg_write, reg_addr); end
      checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL single_early_rsp got %b want 00", rsp_valid); end
      tick;
      checks++; if (rsp_valid !== 2'b01 || rsp_rddata !== 32'h1000_0008) begin
         failures++; $display("FAIL single_rsp got %b/%h want 01/10000008", rsp_valid, rsp_rddata); end
      checks++; if (reg_read !== 1'b0) begin failures++; $display("FAIL single_rd_pulse got %b want 0", reg_read); end
      tick;
      checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL single_rsp_pulse got %b want 00", rsp_valid); end
   endtask

   task automatic test_round_robin;
      logic [1:0] exp;
      int p;
      do_reset;
      req_addr = {64'h30, 64'h20}; req_write = 2'b10;
      req_wrdata = {32'hCAFE_0001, 32'h0}; req_lock = 2'b00;
      for (int k = 0; k < 8; k++) begin
         req_valid = (k < 6) ? 2'b11 : 2'b00;
         #1;
         if (k < 6) begin
            exp = (k % 2 == 1) ? 2'b10 : 2'b01;
            checks++; if (req_ready !== exp) begin failures++; $display("FAIL rr_grant[%0d] got %b want %b", k, req_ready, exp); end
         end
         if (k >= 1 && k <= 6) begin
            p = k - 1;
            exp = (p % 2 == 1) ? 2'b01 : 2'b10;
            checks++; if ({reg_read, reg_write} !== exp || reg_addr !== ((p % 2 == 1) ? 64'h30 : 64'h20)) begin
               failures++; $display("FAIL rr_regop[%0d] got rdwr=%b addr=%h want %b", k, {reg_read, reg_write}, reg_addr, exp); end
         end
         if (k >= 2) begin
            exp = ((k - 2) % 2 == 0) ? 2'b01 : 2'b00;
            checks++; if (rsp_valid !== exp || (exp == 2'b01 && rsp_rddata !== 32'h1000_0020)) begin
               failures++; $display("FAIL rr_rsp[%0d] got %b/%h want %b/10000020", k, rsp_valid, rsp_rddata, exp); end
         end
         tick;
      end
   endtask

   task automatic test_write_then_read;
      do_reset;
      req_valid = 2'b10; req_write = 2'b10;
      req_addr = {64'h10, 64'h0}; req_wrdata = {32'hDEAD_BEEF, 32'h0};
      #1;
      checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL wr_ready got %b want 10", req_ready); end
      tick;
      req_valid = 2'b01; req_write = 2'b00; req_addr = {64'h0, 64'h10};
      #1;
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rd_ready got %b want 01", req_ready); end
      checks++; if (reg_write !== 1'b1 || reg_read !== 1'b0 || reg_addr !== 64'h10 || reg_wrdata !== 32'hDEAD_BEEF) begin
         failures++; $display("FAIL wr_regop got wr=%b rd=%b addr=%h dat=%h want 1/0/10/deadbeef", reg_write, reg_read, reg_addr, reg_wrdata); end
      tick;
      req_valid = 2'b00;
      #1;
      checks++; if (reg_read !== 1'b1 || reg_write !== 1'b0 || rsp_valid !== 2'b00) begin
         failures++; $display("FAIL wr_no_rsp got rd=%b wr=%b rsp=%b want 1/0/00", reg_read, reg_write, rsp_valid); end
      tick;
      checks++; if (rsp_valid !== 2'b01 || rsp_rddata !== 32'hDEAD_BEEF) begin
         failures++; $display("FAIL wr_rd_rsp got %b/%h want 01/deadbeef", rsp_valid, rsp_rddata); end
      tick;
      checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL wr_rd_tail got %b want 00", rsp_valid); end
   endtask

   task automatic test_reset_inflight;
      do_reset;
      req_valid = 2'b10; req_write = 2'b00; req_addr = {64'h8, 64'h0};
      tick;
      nreset = 1'b0;
      req_valid = 2'b00;
      #1;
      checks++; if (reg_read !== 1'b0 || rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
         failures++; $display("FAIL inflight_clear got rd=%b rsp=%b ready=%b want 0/00/00", reg_read, rsp_valid, req_ready); end
      tick;
      nreset = 1'b1;
      req_valid = 2'b11;
      #1;
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL inflight_first_grant got %b want 01", req_ready); end
      req_valid = 2'b00;
      for (int k = 0; k < 3; k++) begin
         tick;
         checks++; if (rsp_valid !== 2'b00 || reg_read !== 1'b0) begin
            failures++; $display("FAIL inflight_no_rsp[%0d] got rsp=%b rd=%b want 00/0", k, rsp_valid, reg_read); end
      end
   endtask

   task automatic test_lock;
      logic [1:0] vld_t [5];
      logic [1:0] lck_t [5];
      logic [1:0] exp_t [5];
      vld_t = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11};
      lck_t = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
`ifdef UMI_REG_ARB_LOCK_EN
      exp_t = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
`else
      exp_t = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`endif
      do_reset;
      req_write = 2'b00; req_addr = {64'h50, 64'h40};
      for (int k = 0; k < 5; k++) begin
         req_valid = vld_t[k];
         req_lock = lck_t[k];
         #1;
         checks++; if (req_ready !== exp_t[k]) begin failures++; $display("FAIL lock_grant[%0d] got %b want %b", k, req_ready, exp_t[k]); end
         tick;
      end
      req_valid = 2'b00; req_lock = 2'b00;
      tick; tick;
   endtask

   task automatic test_rdlat3;
      logic [1:0]  vld_t [3];
      logic [1:0]  e3 [8];
      logic [1:0]  e1 [8];
      logic [31:0] d3 [8];
      logic [31:0] d1 [8];
      vld_t = '{2'b01, 2'b10, 2'b01};
      e3 = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00};
      e1 = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
      d3 = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h3000_0040, 32'h3000_0050, 32'h3000_0044, 32'h0};
      d1 = '{32'h0, 32'h0, 32'h1000_0040, 32'h1000_0050, 32'h1000_0044, 32'h0, 32'h0, 32'h0};
      do_reset;
      req_write = 2'b00; req_lock = 2'b00;
      for (int k = 0; k < 8; k++) begin
         req_valid = (k < 3) ? vld_t[k] : 2'b00;
         req_addr = (k == 2) ? {64'h50, 64'h44} : {64'h50, 64'h40};
         #1;
         if (k >= 1) begin
            checks++; if (rsp_valid3 !== e3[k] || (e3[k] != 2'b00 && rsp_rddata3 !== d3[k])) begin
               failures++; $display("FAIL rdlat3_rsp[%0d] got %b/%h want %b/%h", k, rsp_valid3, rsp_rddata3, e3[k], d3[k]); end
            checks++; if (rsp_valid !== e1[k] || (e1[k] != 2'b00 && rsp_rddata !== d1[k])) begin
               failures++; $display("FAIL rdlat1_order[%0d] got %b/%h want %b/%h", k, rsp_valid, rsp_rddata, e1[k], d1[k]); end
         end
         tick;
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
      test_reset;
      test_single_read;
      test_round_robin;
      test_write_then_read;
      test_reset_inflight;
      test_lock;
      test_rdlat3;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/umi_reg_arbiter.md
UMI_REG_ARBITER -- requirements
Module: umi_reg_arbiter

Interface
REQ-001 Parameter N, default 2: number of requesters sharing one register port (2..8).
REQ-002 Parameter AW, default 64: address width.
REQ-003 Parameter RW, default 32: register data width.
REQ-004 Parameter RDLAT, default 1: cycles from reg_read to valid reg_rddata (1..4).
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 Port clk, input, 1: clock, all state on rising edge.
REQ-007 Port nreset, input, 1: asynchronous active-low reset.
REQ-008 Port req_valid, input, N: requester i has a transaction pending.
REQ-009 Port req_write, input, N: 1 = write, 0 = read.
REQ-010 Port req_lock, input, N: hold grant after this transaction.
REQ-011 Port req_addr, input, N*AW: requester i address in bits [i*AW +: AW].
REQ-012 Port req_wrdata, input, N*RW: requester i write data in bits [i*RW +: RW].
REQ-013 Port req_ready, output, N: one-hot grant; transaction i accepted when req_valid[i] & req_ready[i].
REQ-014 Port rsp_valid, output, N: one-hot read-data strobe for requester i.
REQ-015 Port rsp_rddata, output, RW: read data, qualified by rsp_valid.
REQ-016 Port reg_addr, output, AW; reg_write, output, 1; reg_read, output, 1; reg_wrdata, output, RW: shared register/SRAM port.
REQ-017 Port reg_rddata, input, RW: shared port read data, valid RDLAT cycles after reg_read.

Function
REQ-018 Grant SHALL be combinational from req_valid and round-robin pointer ptr; the highest-priority requester is ptr+1 mod N, then ascending with wrap.
REQ-019 req_ready SHALL be at most one-hot and SHALL be zero when req_valid is zero.
REQ-020 On acceptance at cycle t, ptr SHALL update to the granted index, and reg_addr/reg_wrdata/reg_write/reg_read SHALL be registered and driven at t+1 for exactly one cycle.
REQ-021 reg_write and reg_read SHALL never be asserted together; with no acceptance, both SHALL be 0 the next cycle, and reg_addr/reg_wrdata hold their last values.
REQ-022 Throughput: one accepted transaction per cycle, fully pipelined, with no bubbles between different requesters.
REQ-023 Read accepted at t: rsp_valid[i] asserted at t+1+RDLAT for one cycle, with rsp_rddata = reg_rddata combinationally in that cycle.
REQ-024 Requester ID SHALL travel through an RDLAT-deep shift pipeline; back-to-back reads from mixed requesters return in issue order.
REQ-025 Writes SHALL produce no rsp_valid.
REQ-026 rsp_rddata SHALL be don't-care when rsp_valid is zero.
REQ-027 A requester deasserting req_valid without a grant SHALL be legal; req_* fields SHALL be sampled only at acceptance.

Reset
REQ-028 Assertion of nreset SHALL asynchronously clear reg_write, reg_read, reg_addr, reg_wrdata, the response pipeline and the lock state.
REQ-029 Reset SHALL set ptr = N-1, so requester 0 has first priority.
REQ-030 Outputs during reset: req_ready = 0, rsp_valid = 0.
REQ-031 Transactions in flight when reset asserts SHALL be discarded with no rsp_valid after release.
REQ-032 Reset release SHALL be synchronized externally.

Configuration
REQ-033 With macro UMI_REG_ARB_LOCK_EN defined, acceptance with req_lock[i]=1 SHALL lock the grant to i.
REQ-034 While locked, all other requesters SHALL see req_ready = 0, and the lock SHALL clear on i's next accepted transaction with req_lock[i]=0.
REQ-035 Without UMI_REG_ARB_LOCK_EN, req_lock SHALL be present but ignored, with pure round-robin.

Verification
REQ-036 Reset released, req_valid=2'b01, read addr 0x8 -> reg_read=1/reg_addr=0x8 at t+1; rsp_valid=2'b01 with SRAM data at t+2 (RDLAT=1).
REQ-037 Both requesters continuously valid for 6 cycles -> grants alternate 0,1,0,1,0,1; reg_read/reg_write asserted every cycle.
REQ-038 Write 0xDEADBEEF to 0x10 by req 1, then read 0x10 by req 0 next cycle -> rsp_valid=2'b01, rsp_rddata=0xDEADBEEF, no rsp for the write.
REQ-039 nreset asserted one cycle after a read is accepted -> no rsp_valid after release; reg_read=0; first grant goes to requester 0.
REQ-040 UMI_REG_ARB_LOCK_EN: req 1 issues 3 reads with lock=1,1,0 while req 0 is valid -> req 0 is granted only after the third read.
REQ-041 RDLAT=3, interleaved reads from reqs 0,1,0 -> rsp_valid = 01, 10, 01 on consecutive cycles starting at t+4.
